// File: rtl/count_display_pkg.sv
// Shared types and constants for the stopwatch display path: converter states,
// saturation limit and the active-low seven-segment decode.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam logic [13:0] MAX_COUNT = 14'd9999;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // Segments g..a, active-low; non-decimal nibbles go dark.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_pattern = 7'b1000000;
      4'd1:    seg_pattern = 7'b1111001;
      4'd2:    seg_pattern = 7'b0100100;
      4'd3:    seg_pattern = 7'b0110000;
      4'd4:    seg_pattern = 7'b0011001;
      4'd5:    seg_pattern = 7'b0010010;
      4'd6:    seg_pattern = 7'b0000010;
      4'd7:    seg_pattern = 7'b1111000;
      4'd8:    seg_pattern = 7'b0000000;
      4'd9:    seg_pattern = 7'b0010000;
      default: seg_pattern = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary (saturated at 9999) to four BCD
// digits, one shift per cycle, committing the result atomically.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] count_in,
  output logic [15:0] bcd_out,
  output logic        busy
);

  conv_state_t state_reg, state_next;
  logic [13:0] last_val_reg, last_val_next;
  logic        force_reg, force_next;
  logic [13:0] bin_reg, bin_next;
  logic [15:0] scratch_reg, scratch_next;
  logic [3:0]  iter_reg, iter_next;
  logic [15:0] bcd_reg, bcd_next;
  logic [15:0] adj;
  logic [13:0] sat;

  assign sat = (count_in > MAX_COUNT) ? MAX_COUNT : count_in;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                              scratch_reg[gi*4 +: 4] + 4'd3 : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      last_val_reg <= '0;
      force_reg    <= 1'b1;
      bin_reg      <= '0;
      scratch_reg  <= '0;
      iter_reg     <= '0;
      bcd_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      last_val_reg <= last_val_next;
      force_reg    <= force_next;
      bin_reg      <= bin_next;
      scratch_reg  <= scratch_next;
      iter_reg     <= iter_next;
      bcd_reg      <= bcd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    last_val_next = last_val_reg;
    force_next    = force_reg;
    bin_next      = bin_reg;
    scratch_next  = scratch_reg;
    iter_next     = iter_reg;
    bcd_next      = bcd_reg;
    case (state_reg)
      IDLE: begin
        // last_val keeps the raw input so saturated-to-saturated changes still retrigger
        if (force_reg || (count_in != last_val_reg)) begin
          bin_next      = sat;
          last_val_next = count_in;
          force_next    = 1'b0;
          scratch_next  = '0;
          iter_next     = '0;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, bin_next} = {adj[14:0], bin_reg, 1'b0};
        iter_next = iter_reg + 4'd1;
        if (iter_reg == 4'd13) state_next = DONE;
      end
      DONE: begin
        bcd_next   = scratch_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bcd_out = bcd_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: rtl/count_display.sv
// Stopwatch display: BCD conversion of the centisecond count and a
// time-multiplexed common-anode seven-segment driver showing SS.hh.
module count_display
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DP_POS      = 2,
  parameter int BLANK_LEAD  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] count_in,
  output logic [15:0] bcd_out,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  logic [16:0] refresh_reg;
  logic [1:0]  idx_reg;
  logic [6:0]  seg_reg, seg_next;
  logic        dp_reg, dp_next;
  logic [3:0]  an_reg, an_next;
  logic [3:0]  digits [4];
  logic        terminal;

  bin2bcd_seq u_conv (
    .clk      (clk),
    .reset_n  (reset_n),
    .count_in (count_in),
    .bcd_out  (bcd_out),
    .busy     (busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digits[gi] = bcd_out[gi*4 +: 4];
    end
  endgenerate

  assign terminal = (refresh_reg == 17'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_reg <= '0;
      idx_reg     <= '0;
    end else if (terminal) begin
      refresh_reg <= '0;
      idx_reg     <= idx_reg + 2'd1;
    end else begin
      refresh_reg <= refresh_reg + 17'd1;
    end
  end

  always_comb begin
    seg_next = seg_pattern(digits[idx_reg]);
    if ((BLANK_LEAD != 0) && (idx_reg == 2'd3) && (digits[3] == 4'd0))
      seg_next = SEG_BLANK;
    dp_next = (idx_reg == 2'(DP_POS)) ? 1'b0 : 1'b1;
    an_next = ~(4'b0001 << idx_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
      an_reg  <= 4'b1111;
    end else begin
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      an_reg  <= an_next;
    end
  end

  assign seg = seg_reg;
  assign dp  = dp_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_count_display.sv
// Scoreboarded bench for count_display: conversions are queued by the stimulus
// and checked by a monitor on every busy falling edge; scan output checked inline.
module tb_count_display;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] count_in = '0;
  logic [15:0] bcd_out, bcd_nb;
  logic        busy, busy_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [3:0]  an, an_nb;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  count_display #(.REFRESH_DIV(4), .DP_POS(2), .BLANK_LEAD(1)) dut (
    .clk(clk), .reset_n(reset_n), .count_in(count_in), .bcd_out(bcd_out),
    .busy(busy), .seg(seg), .dp(dp), .an(an)
  );

  count_display #(.REFRESH_DIV(4), .DP_POS(2), .BLANK_LEAD(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .count_in(count_in), .bcd_out(bcd_nb),
    .busy(busy_nb), .seg(seg_nb), .dp(dp_nb), .an(an_nb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every conversion commit pops one expectation.
  int  hi_cnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      hi_cnt    = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) hi_cnt++;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", 32'(bcd_out), 32'hDEAD);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          $display("commit bcd_out=%04h expected=%04h busy_cycles=%0d", bcd_out, e, hi_cnt);
          chk("commit_bcd", 32'(bcd_out), 32'(e));
          chk("busy_len", 32'(hi_cnt), 32'd15);
        end
        hi_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic conv(input logic [13:0] v, input logic [15:0] e);
    wait_idle();
    count_in = v;
    exp_q.push_back(e);
    @(negedge clk);
    chk("busy_rise", 32'(busy), 32'd1);
    repeat (14) @(negedge clk);
    chk("busy_hold", 32'(busy), 32'd1);
    @(negedge clk);
    chk("bcd_edge16", 32'(bcd_out), 32'(e));
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  // Wait until `an` has just moved from `from` to `to`; bounded.
  task automatic sync_an(input logic [3:0] from, input logic [3:0] to);
    logic [3:0] prev;
    int n;
    prev = an;
    n = 0;
    @(negedge clk);
    while (!(an == to && prev == from) && n < 40) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    chk("scan_sync", 32'(an), 32'(to));
  endtask

  logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_tab [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);

    // Forced conversion after release
    #2 reset_n = 1'b1;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd1);
    repeat (15) @(negedge clk);
    chk("post_rst_bcd", 32'(bcd_out), 32'h0000);
    chk("post_rst_idle", 32'(busy), 32'd0);

    conv(14'd1234, 16'h1234);
    conv(14'd9999, 16'h9999);
    conv(14'd0, 16'h0000);
    conv(14'd12000, 16'h9999);
    conv(14'd16383, 16'h9999);
    conv(14'd1234, 16'h1234);

    // Scan: one full frame of digits
    sync_an(4'b0111, 4'b1110);
    for (int k = 0; k < 16; k++) begin
      chk("scan_an", 32'(an), 32'(an_tab[k / 4]));
      chk("scan_seg", 32'(seg), 32'(seg_tab[k / 4]));
      chk("scan_dp", 32'(dp), (k / 4 == 2) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    $display("scan frame checked for 1234");

    // Leading blank
    conv(14'd567, 16'h0567);
    sync_an(4'b1011, 4'b0111);
    for (int k = 0; k < 4; k++) begin
      chk("blank_seg", 32'(seg), 32'h7F);
      chk("noblank_seg", 32'(seg_nb), 32'h40);
      chk("blank_an", 32'(an), 32'h7);
      @(negedge clk);
    end
    $display("leading blank checked for 567");

    // Change during SHIFT iteration 5
    wait_idle();
    count_in = 14'd1234;
    exp_q.push_back(16'h1234);
    repeat (6) @(negedge clk);
    count_in = 14'd4321;
    exp_q.push_back(16'h4321);
    repeat (10) @(negedge clk);
    chk("mid_first_bcd", 32'(bcd_out), 32'h1234);
    chk("mid_first_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("mid_restart_busy", 32'(busy), 32'd1);
    repeat (15) @(negedge clk);
    chk("mid_second_bcd", 32'(bcd_out), 32'h4321);

    // Reset during SHIFT iteration 7
    wait_idle();
    count_in = 14'd777;
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_bcd", 32'(bcd_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'd1);
    chk("arst_an", 32'(an), 32'hF);
    count_in = 14'd42;
    @(negedge clk);
    #2 reset_n = 1'b1;
    exp_q.push_back(16'h0042);
    @(negedge clk);
    chk("rerun_busy", 32'(busy), 32'd1);
    repeat (14) @(negedge clk);
    chk("rerun_edge15", 32'(bcd_out), 32'd0);
    @(negedge clk);
    chk("rerun_edge16", 32'(bcd_out), 32'h0042);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
